// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM encoding for the sequential execute-stage ALU.
// Imported by the ALU interface, datapath and multiply/divide engine.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// ALU request/response bundle: in_valid/in_ready op channel and
// out_valid/out_ready result channel with HI/LO results and z/ovf/dz flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cont;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             z;
  logic             ovf;
  logic             dz;

  modport master (
    output in_valid, alu_cont, op1, op2, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, z, ovf, dz
  );

  modport slave (
    input  in_valid, alu_cont, op1, op2, out_ready,
    output in_ready, out_valid, result_lo, result_hi, z, ovf, dz
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative MULTU/DIVU engine: one shared HI/LO shift register, WIDTH steps.
// Ports: start/a/b load, busy/done status, hi_nxt/lo_nxt next-step result.
// Divider datapath present only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // Shift-add: LO holds the multiplier, product shifts in from the top.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  // Restoring step: HI is the partial remainder, LO collects quotient bits.
  // A borrow out of div_diff (bit WIDTH) means the divisor did not fit.
  always_comb begin
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[WIDTH];
    hi_nxt   = mul_hi;
    lo_nxt   = mul_lo;
    if (div_q) begin
      hi_nxt = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end
  end
`else
  always_comb begin
    hi_nxt = mul_hi;
    lo_nxt = mul_lo;
  end
`endif

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= is_div;
`endif
    end else if (busy_q) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops, iterative MULTU/DIVU.
// Ports: clk, rst_n (sync, active-low), bus (alu_seq_if slave). DIVU needs ALU_SEQ_DIV_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             z_q;
  logic             ovf_q;

  logic is_and, is_or, is_add, is_nor;
  logic is_sub, is_slt, is_sltu, is_mul;

  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   dif_full;
  logic [WIDTH-1:0] dif;
  logic             borrow;
  logic             add_ovf;
  logic             sub_ovf;

  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_z;
  logic             sc_ovf;
  logic             sc_known;
  logic             go_iter;

  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  assign is_and  = bus.alu_cont == OP_AND;
  assign is_or   = bus.alu_cont == OP_OR;
  assign is_add  = bus.alu_cont == OP_ADD;
  assign is_nor  = bus.alu_cont == OP_NOR;
  assign is_sub  = bus.alu_cont == OP_SUB;
  assign is_slt  = bus.alu_cont == OP_SLT;
  assign is_sltu = bus.alu_cont == OP_SLTU;
  assign is_mul  = bus.alu_cont == OP_MULTU;

`ifdef ALU_SEQ_DIV_EN
  logic is_div;
  logic sc_dz;
  logic dz_q;
  assign is_div = bus.alu_cont == OP_DIVU;
`endif

  // Subtract as op1 + ~op2 + 1 so the carry-out doubles as "no borrow".
  always_comb begin
    sum      = bus.op1 + bus.op2;
    dif_full = {1'b0, bus.op1} + {1'b0, ~bus.op2} + (WIDTH+1)'(1);
    dif      = dif_full[WIDTH-1:0];
    borrow   = ~dif_full[WIDTH];
    add_ovf  = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1])
            && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
    sub_ovf  = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1])
            && (dif[WIDTH-1] != bus.op1[WIDTH-1]);
  end

  always_comb begin
    sc_lo    = '0;
    sc_hi    = '0;
    sc_ovf   = 1'b0;
    sc_known = 1'b1;
    go_iter  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    sc_dz    = 1'b0;
`endif
    unique case (1'b1)
      is_and:  sc_lo = bus.op1 & bus.op2;
      is_or:   sc_lo = bus.op1 | bus.op2;
      is_nor:  sc_lo = ~(bus.op1 | bus.op2);
      is_add: begin
        sc_lo  = sum;
        sc_ovf = add_ovf;
      end
      is_sub: begin
        sc_lo  = dif;
        sc_ovf = sub_ovf;
      end
      // Signed less-than must correct the sign bit when the subtract overflows.
      is_slt:  sc_lo = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ sub_ovf};
      is_sltu: sc_lo = {{(WIDTH-1){1'b0}}, borrow};
      is_mul:  go_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      // Divide by zero skips the engine and answers at once.
      is_div: begin
        if (bus.op2 == '0) begin
          sc_lo = '1;
          sc_hi = bus.op1;
          sc_dz = 1'b1;
        end else begin
          go_iter = 1'b1;
        end
      end
`endif
      default: sc_known = 1'b0;
    endcase
    sc_z = sc_known && (sc_lo == '0);
  end

  assign md_start = bus.in_valid && (state_q == IDLE) && go_iter;

  alu_seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
`ifdef ALU_SEQ_DIV_EN
    .is_div (is_div),
`endif
    .a      (bus.op1),
    .b      (bus.op2),
    .busy   (md_busy),
    .done   (md_done),
    .hi_nxt (md_hi),
    .lo_nxt (md_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      z_q         <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (go_iter) begin
              state_q <= BUSY;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              lo_q        <= sc_lo;
              hi_q        <= sc_hi;
              z_q         <= sc_z;
              ovf_q       <= sc_ovf;
`ifdef ALU_SEQ_DIV_EN
              dz_q        <= sc_dz;
`endif
            end
          end
        end
        BUSY: begin
          // Capture the engine's final step as it is being computed.
          if (md_busy && md_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            lo_q        <= md_lo;
            hi_q        <= md_hi;
            z_q         <= (md_lo == '0);
            ovf_q       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            dz_q        <= 1'b0;
`endif
          end else if (!md_busy) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.z         = z_q;
  assign bus.ovf       = ovf_q;
`ifdef ALU_SEQ_DIV_EN
  assign bus.dz        = dz_q;
`else
  assign bus.dz        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32 and WIDTH=8.
// DIVU expectations follow the ALU_SEQ_DIV_EN build setting.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic        z;
    logic        ovf;
  } sc_vec_t;

  sc_vec_t sc_tab [17] = '{
    '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
    '{OP_ADD,  32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b1, 1'b0},
    '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
    '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
    '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
    '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0},
    '{OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0},
    '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
    '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0},
    '{OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0},
    '{OP_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0},
    '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_NOR,  32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0},
    '{4'b1111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0},
    '{4'b0100, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0}
  };

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        dz;
    logic [7:0]  lat;
  } it_vec_t;

  it_vec_t mul_tab [3] = '{
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 8'd33},
    '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0, 8'd33},
    '{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 8'd33}
  };

`ifdef ALU_SEQ_DIV_EN
  it_vec_t div_tab [4] = '{
    '{32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 8'd33},
    '{32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b0, 1'b1, 8'd1},
    '{32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 8'd33},
    '{32'd5,        32'd7,        32'd5,        32'd0,        1'b1, 1'b0, 8'd33}
  };
`else
  it_vec_t div_tab [2] = '{
    '{32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 8'd1},
    '{32'd9,   32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd1}
  };
`endif

  task automatic send32(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    b32.alu_cont = op;
    b32.op1      = a;
    b32.op2      = b;
    b32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    b32.alu_cont = 4'hF;
    b32.op1      = 32'hDEADBEEF;
    b32.op2      = 32'h0BADF00D;
  endtask

  task automatic wait32(output int lat, output bit rdy);
    lat = 1;
    rdy = 1'b0;
    while (!b32.out_valid && lat < 100) begin
      if (b32.in_ready) rdy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain32();
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({b32.out_valid, b32.in_ready, b32.result_lo, b32.result_hi,
         b32.z, b32.ovf, b32.dz} !== {2'b01, 64'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset32: got v=%b r=%b lo=%h hi=%h z=%b o=%b d=%b, expected v=0 r=1 all 0",
               b32.out_valid, b32.in_ready, b32.result_lo, b32.result_hi,
               b32.z, b32.ovf, b32.dz);
    end
    vectors++;
    if ({b8.out_valid, b8.in_ready, b8.result_lo, b8.result_hi,
         b8.z, b8.ovf, b8.dz} !== {2'b01, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset8: got v=%b r=%b lo=%h hi=%h, expected v=0 r=1 all 0",
               b8.out_valid, b8.in_ready, b8.result_lo, b8.result_hi);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_cycle();
    int lat;
    bit rdy;
    for (int i = 0; i < 17; i++) begin
      send32(sc_tab[i].op, sc_tab[i].a, sc_tab[i].b);
      wait32(lat, rdy);
      vectors++;
      if ({b32.result_lo, b32.result_hi, b32.z, b32.ovf, b32.dz} !==
          {sc_tab[i].lo, 32'h0, sc_tab[i].z, sc_tab[i].ovf, 1'b0}) begin
        miscompares++;
        $display("FAIL sc[%0d] op=%b: got lo=%h hi=%h z=%b ovf=%b dz=%b, expected lo=%h hi=0 z=%b ovf=%b dz=0",
                 i, sc_tab[i].op, b32.result_lo, b32.result_hi, b32.z,
                 b32.ovf, b32.dz, sc_tab[i].lo, sc_tab[i].z, sc_tab[i].ovf);
      end
      vectors++;
      if (lat != 1) begin
        miscompares++;
        $display("FAIL sc_lat[%0d]: got %0d expected 1", i, lat);
      end
      drain32();
    end
  endtask

  task automatic test_multu();
    int lat;
    bit rdy;
    for (int i = 0; i < 3; i++) begin
      send32(OP_MULTU, mul_tab[i].a, mul_tab[i].b);
      wait32(lat, rdy);
      vectors++;
      if ({b32.result_hi, b32.result_lo, b32.z, b32.ovf, b32.dz} !==
          {mul_tab[i].hi, mul_tab[i].lo, mul_tab[i].z, 2'b00}) begin
        miscompares++;
        $display("FAIL multu[%0d]: got hi=%h lo=%h z=%b ovf=%b dz=%b, expected hi=%h lo=%h z=%b",
                 i, b32.result_hi, b32.result_lo, b32.z, b32.ovf, b32.dz,
                 mul_tab[i].hi, mul_tab[i].lo, mul_tab[i].z);
      end
      vectors++;
      if (lat != int'(mul_tab[i].lat) || rdy || b32.in_ready) begin
        miscompares++;
        $display("FAIL multu_lat[%0d]: got lat=%0d ready_seen=%b, expected lat=%0d ready_seen=0",
                 i, lat, rdy | b32.in_ready, mul_tab[i].lat);
      end
      drain32();
    end
  endtask

  task automatic test_divu();
    int lat;
    bit rdy;
    for (int i = 0; i < $size(div_tab); i++) begin
      send32(OP_DIVU, div_tab[i].a, div_tab[i].b);
      wait32(lat, rdy);
      vectors++;
      if ({b32.result_hi, b32.result_lo, b32.z, b32.ovf, b32.dz} !==
          {div_tab[i].hi, div_tab[i].lo, div_tab[i].z, 1'b0, div_tab[i].dz}) begin
        miscompares++;
        $display("FAIL divu[%0d]: got hi=%h lo=%h z=%b ovf=%b dz=%b, expected hi=%h lo=%h z=%b dz=%b",
                 i, b32.result_hi, b32.result_lo, b32.z, b32.ovf, b32.dz,
                 div_tab[i].hi, div_tab[i].lo, div_tab[i].z, div_tab[i].dz);
      end
      vectors++;
      if (lat != int'(div_tab[i].lat)) begin
        miscompares++;
        $display("FAIL divu_lat[%0d]: got %0d expected %0d", i, lat,
                 div_tab[i].lat);
      end
      drain32();
    end
  endtask

  task automatic test_hold();
    int lat;
    bit rdy;
    send32(OP_OR, 32'hF0000000, 32'h0000000F);
    wait32(lat, rdy);
    b32.alu_cont = OP_ADD;
    b32.op1      = 32'h1;
    b32.op2      = 32'h1;
    b32.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({b32.out_valid, b32.in_ready, b32.result_lo, b32.result_hi,
           b32.z, b32.ovf} !== {2'b10, 32'hF000000F, 32'h0, 2'b00}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got v=%b r=%b lo=%h hi=%h z=%b o=%b, expected v=1 r=0 lo=f000000f hi=0",
                 c, b32.out_valid, b32.in_ready, b32.result_lo,
                 b32.result_hi, b32.z, b32.ovf);
      end
    end
    b32.in_valid = 1'b0;
    drain32();
    vectors++;
    if ({b32.out_valid, b32.in_ready, b32.result_lo} !==
        {2'b01, 32'hF000000F}) begin
      miscompares++;
      $display("FAIL hold_drain: got v=%b r=%b lo=%h, expected v=0 r=1 lo=f000000f",
               b32.out_valid, b32.in_ready, b32.result_lo);
    end
  endtask

  task automatic test_back_to_back();
    int n_out;
    bit bad;
    n_out = 0;
    bad = 1'b0;
    b32.alu_cont  = OP_ADD;
    b32.op1       = 32'd2;
    b32.op2       = 32'd3;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (b32.out_valid) begin
        n_out++;
        if (b32.in_ready || b32.result_lo !== 32'd5) bad = 1'b1;
      end
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b0;
    vectors++;
    if (n_out != 5) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results in 10 cycles, expected 5", n_out);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL b2b_data: got ready/result wrong on a drain cycle, expected r=0 lo=5");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_busy();
    int seen;
    send32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy10: got r=%b v=%b, expected r=0 v=0",
               b32.in_ready, b32.out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if ({b32.out_valid, b32.in_ready, b32.result_lo, b32.result_hi,
         b32.z, b32.ovf, b32.dz} !== {2'b01, 64'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL rst_busy: got v=%b r=%b lo=%h hi=%h z=%b o=%b d=%b, expected v=0 r=1 all 0",
               b32.out_valid, b32.in_ready, b32.result_lo, b32.result_hi,
               b32.z, b32.ovf, b32.dz);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (b32.out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_abort: got %0d cycles of out_valid, expected 0", seen);
    end
  endtask

  task automatic test_width8();
    logic [3:0] ops [3];
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [7:0] ehi [3];
    logic [7:0] elo [3];
    logic       eovf [3];
    int         elat [3];
    int         lat;
    ops  = '{OP_MULTU, OP_MULTU, OP_ADD};
    av   = '{8'hFF, 8'h0F, 8'h7F};
    bv   = '{8'hFF, 8'h11, 8'h01};
    ehi  = '{8'hFE, 8'h00, 8'h00};
    elo  = '{8'h01, 8'hFF, 8'h80};
    eovf = '{1'b0, 1'b0, 1'b1};
    elat = '{9, 9, 1};
    for (int i = 0; i < 3; i++) begin
      b8.alu_cont = ops[i];
      b8.op1      = av[i];
      b8.op2      = bv[i];
      b8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      b8.in_valid = 1'b0;
      b8.op1      = 8'h00;
      b8.op2      = 8'h00;
      lat = 1;
      while (!b8.out_valid && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      vectors++;
      if ({b8.result_hi, b8.result_lo, b8.ovf} !== {ehi[i], elo[i], eovf[i]}) begin
        miscompares++;
        $display("FAIL w8[%0d]: got hi=%h lo=%h ovf=%b, expected hi=%h lo=%h ovf=%b",
                 i, b8.result_hi, b8.result_lo, b8.ovf, ehi[i], elo[i], eovf[i]);
      end
      vectors++;
      if (lat != elat[i]) begin
        miscompares++;
        $display("FAIL w8_lat[%0d]: got %0d expected %0d", i, lat, elat[i]);
      end
      b8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b8.out_ready = 1'b0;
    end
  endtask

  initial begin
    b32.in_valid  = 1'b0;
    b32.alu_cont  = 4'h0;
    b32.op1       = '0;
    b32.op2       = '0;
    b32.out_ready = 1'b0;
    b8.in_valid   = 1'b0;
    b8.alu_cont   = 4'h0;
    b8.op1        = '0;
    b8.op2        = '0;
    b8.out_ready  = 1'b0;
    test_reset();
    test_single_cycle();
    test_multu();
    test_divu();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
